// File: rtl/uart_pkg.sv
// Shared UART definitions for the SIN receiver and the SOUT transmitter, so the
// bit period and frame layout are defined in one place.
package uart_pkg;
  localparam int UART_CLKS_PER_BIT = 217;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/dff_uart_tx_if.sv
// Byte write handshake into the UART transmit queue.
interface dff_uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous circular-buffer FIFO. The pointers carry one extra MSB so that
// full and empty can be told apart without a separate counter.
module byte_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]                wr_ptr_q, wr_ptr_d;
  logic [AW:0]                rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][DW-1:0]   mem_q, mem_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = CNT_W'(wr_ptr_q - rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/dff_uart_tx.sv
// 8N1 serial transmitter returning DFF results to the Raspberry Pi on SOUT.
// Bytes are queued in byte_fifo and sent LSB first; frames from the queue are contiguous.
module dff_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic              CLK_50M,
  input  logic              RST_PER_N,
  dff_uart_tx_if.slave      tx_if,
  input  logic              clr_ovf,
  output logic              SOUT,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e                state_q, state_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                       sout_q, sout_d;
  logic                       busy_q, busy_d;
  logic                       ovf_q, ovf_d;

  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0]  fifo_dout;
  logic                       bit_end;

  assign tx_if.tx_ready = !fifo_full;
  assign fifo_push      = tx_if.tx_valid && !fifo_full;

  byte_fifo #(
    .DW    (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (CLK_50M),
    .rst_n (RST_PER_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (tx_if.tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d    = '0;
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == BIT_LAST) state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames have no gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SOUT and tx_busy are both registered off state_q, so they trail the FSM by
  // one cycle and bracket exactly the same 10-bit window on the wire.
  always_comb begin
    sout_d = 1'b1;
    case (state_q)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shreg_q[0];
      default: sout_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE);
    ovf_d  = ovf_q;
    if (tx_if.tx_valid && fifo_full) ovf_d = 1'b1;
    else if (clr_ovf)                ovf_d = 1'b0;
  end

  always_ff @(posedge CLK_50M) begin
    if (!RST_PER_N) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      sout_q    <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      sout_q    <= sout_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign SOUT     = sout_q;
  assign tx_busy  = busy_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_dff_uart_tx.sv
// Bench for dff_uart_tx: a frame-timeline model predicts every output each cycle,
// and a behavioural 8N1 receiver decodes SOUT for byte-level checks.
module tb_dff_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = UART_CLKS_PER_BIT;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          sout, tx_busy, overflow;
  logic [CW-1:0] fifo_count;

  dff_uart_tx_if tif ();

  dff_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .CLK_50M    (clk),
    .RST_PER_N  (rst_n),
    .tx_if      (tif.slave),
    .clr_ovf    (clr_ovf),
    .SOUT       (sout),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of waiting bytes plus a single frame timeline t=0..FRAME-1.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  logic [7:0] m_q[$];
  bit         m_act = 0;
  int         m_t = 0;
  logic [7:0] m_byte = '0;
  bit         m_ovf = 0;
  bit         m_valid = 0;
  logic       e_sout = 1'b1;
  logic       e_busy = 1'b0;

  always @(posedge clk) begin
    bit rdy, fend, canpop;
    cyc++;
    if (!rst_n) begin
      m_q.delete();
      m_act = 0; m_t = 0; m_ovf = 0;
      e_sout = 1'b1; e_busy = 1'b0;
      m_valid = 1;
    end else begin
      rdy    = (m_q.size() < DEPTH);
      fend   = m_act && (m_t == FRAME - 1);
      canpop = (!m_act || fend) && (m_q.size() > 0);
      e_sout = m_act ? frame_bit(m_byte, m_t / CPB) : 1'b1;
      e_busy = m_act;
      if (canpop) begin
        m_byte = m_q.pop_front();
        m_act = 1; m_t = 0;
      end else if (fend) begin
        m_act = 0;
      end else if (m_act) begin
        m_t++;
      end
      if (tif.tx_valid && rdy) m_q.push_back(tif.tx_data);
      if (tif.tx_valid && !rdy) m_ovf = 1;
      else if (clr_ovf)         m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("sout",       32'(sout),          32'(e_sout));
      chk("tx_busy",    32'(tx_busy),       32'(e_busy));
      chk("fifo_count", 32'(fifo_count),    32'(m_q.size()));
      chk("tx_ready",   32'(tif.tx_ready),  32'(m_q.size() < DEPTH));
      chk("overflow",   32'(overflow),      32'(m_ovf));
    end
  end

  // Behavioural receiver: mid-bit sampling of SOUT.
  bit         rx_act = 0;
  int         rx_t = 0;
  logic [9:0] rx_bits = '0;
  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         rx_ferr = 0;

  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      rx_act = 0;
    end else begin
      if (!rx_act) begin
        if (sout === 1'b0) begin
          rx_act = 1; rx_t = 0;
          rx_start.push_back(cyc);
        end
      end else begin
        rx_t++;
      end
      if (rx_act && (rx_t % CPB == CPB / 2)) begin
        k = rx_t / CPB;
        rx_bits[k] = sout;
        if (k == 9) begin
          rx_act = 0;
          if (rx_bits[9] !== 1'b1 || rx_bits[0] !== 1'b0) rx_ferr++;
          rx_q.push_back(rx_bits[8:1]);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    tif.tx_valid = 1'b1;
    tif.tx_data  = d;
    @(negedge clk);
    tif.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while ((tx_busy !== 1'b0 || fifo_count !== '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({"idle_", nm}, 32'(n < budget), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=95000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, nlow;
    logic [7:0] exp_q[$];
    tif.tx_valid = 1'b0;
    tif.tx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_sout",  32'(sout), 1);
    chk("rst_busy",  32'(tx_busy), 0);
    chk("rst_ready", 32'(tif.tx_ready), 1);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf",   32'(overflow), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single byte, latency and frame shape
    rx_q.delete();
    @(negedge clk); tif.tx_valid = 1'b1; tif.tx_data = 8'hAB;
    @(negedge clk); tif.tx_valid = 1'b0;
    lat = 0;
    while (sout !== 1'b0 && lat < 10) begin @(negedge clk); lat++; end
    chk("t1_start_latency", 32'(lat), 2);
    n = 0;
    while (tx_busy === 1'b1 && n < FRAME + 10) begin n++; @(negedge clk); end
    chk("t1_busy_cycles", 32'(n), 32'(FRAME));
    chk("t1_frame_bits", 32'(rx_bits), 32'(10'b1101010110));
    chk("t1_rx_count", 32'(rx_q.size()), 1);
    if (rx_q.size() > 0) chk("t1_rx_byte", 32'(rx_q[0]), 32'h AB);

    // 2: two bytes back to back
    rx_q.delete(); rx_start.delete();
    @(negedge clk); tif.tx_valid = 1'b1; tif.tx_data = 8'hAB;
    @(negedge clk); tif.tx_data = 8'hCD;
    @(negedge clk); tif.tx_valid = 1'b0;
    chk("t2_count_a", 32'(fifo_count), 1);
    @(negedge clk);
    chk("t2_count_b", 32'(fifo_count), 1);
    n = 0;
    while (rx_start.size() < 2 && n < 2 * FRAME + 50) begin @(negedge clk); n++; end
    chk("t2_second_start_seen", 32'(rx_start.size()), 2);
    chk("t2_count_after_pop", 32'(fifo_count), 0);
    if (rx_start.size() == 2) chk("t2_gap", 32'(rx_start[1] - rx_start[0]), 32'(FRAME));
    wait_idle("t2", 3 * FRAME);
    chk("t2_frame2_bits", 32'(rx_bits), 32'(10'b1110011010));
    chk("t2_rx_count", 32'(rx_q.size()), 2);

    // 3: fill while busy, overflow on the 17th byte
    rx_q.delete();
    push(8'h5A);
    n = 0;
    while (tx_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t3_busy", 32'(tx_busy), 1);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) begin
        chk("t3_full_count", 32'(fifo_count), 16);
        chk("t3_full_ready", 32'(tif.tx_ready), 0);
        chk("t3_ovf_before", 32'(overflow), 0);
      end
      tif.tx_valid = 1'b1;
      tif.tx_data  = 8'(i);
    end
    @(negedge clk); tif.tx_valid = 1'b0;
    chk("t3_ovf_set", 32'(overflow), 1);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);

    // 4: hold tx_valid on a full FIFO through the pop cycle
    @(negedge clk); tif.tx_valid = 1'b1; tif.tx_data = 8'h77;
    n = 0;
    while (fifo_count !== 5'd15 && n < FRAME + 50) begin @(negedge clk); n++; end
    chk("t4_pop_seen", 32'(n < FRAME + 50), 1);
    chk("t4_ready_after_pop", 32'(tif.tx_ready), 1);
    @(negedge clk); tif.tx_valid = 1'b0;
    chk("t4_count_refill", 32'(fifo_count), 16);
    chk("t4_ready_full", 32'(tif.tx_ready), 0);
    chk("t4_ovf_held", 32'(overflow), 1);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    wait_idle("t34", 18 * FRAME + 100);
    exp_q.delete();
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h77);
    chk("t34_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("t34_rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));

    // 5: reset in the middle of data bit 4 with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); tif.tx_valid = 1'b1; tif.tx_data = 8'(8'h11 * (i + 1));
    end
    @(negedge clk); tif.tx_valid = 1'b0;
    n = 0;
    while (sout !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("t5_started", 32'(sout), 0);
    chk("t5_queued", 32'(fifo_count), 3);
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_sout", 32'(sout), 1);
    chk("t5_count", 32'(fifo_count), 0);
    chk("t5_busy", 32'(tx_busy), 0);
    rst_n = 1'b1;
    nlow = 0;
    repeat (FRAME) begin @(negedge clk); if (sout === 1'b0) nlow++; end
    chk("t5_no_start", 32'(nlow), 0);

    // 6: loopback patterns plus random bytes with random gaps
    rx_q.delete(); exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < exp_q.size(); i++) begin
      push(exp_q[i]);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    wait_idle("t6", 12 * FRAME);
    chk("t6_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("t6_rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    chk("framing_errors", 32'(rx_ferr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dff_uart_tx.md
# dff_uart_tx

Serial transmitter that returns DFF test results and status bytes from the FPGA to the Raspberry Pi over the SOUT line. It is the return path of the existing SIN receive link and uses the same 8N1 frame format and bit period. Result bytes are queued in a small FIFO, then serialised LSB-first on SOUT. SOUT idles high.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 217: CLK_50M cycles per bit. 217 cycles × 20 ns = 4340 ns, matching the SIN bit period of about 4330 ns.
- `FIFO_DEPTH`, default 16: byte queue depth; must be a power of 2, at least 2.
- `CNT_W`, default 5: width of `fifo_count`, equal to log2(FIFO_DEPTH)+1.

Ports:
- `CLK_50M` in 1: the single system clock.
- `RST_PER_N` in 1: synchronous, active-low reset.
- `tx_data` in 8: byte to queue.
- `tx_valid` in 1: `tx_data` is valid this cycle.
- `tx_ready` out 1: the FIFO can accept a byte; equals `!full`.
- `clr_ovf` in 1: clears the `overflow` flag.
- `SOUT` out 1: serial output to the Raspberry Pi; idles high.
- `tx_busy` out 1: a frame is in progress (FSM is not in IDLE).
- `fifo_count` out CNT_W: number of bytes queued, excluding the byte currently being sent.
- `overflow` out 1: sticky flag; set on any write attempt while full.

## Operation

Write handshake:
- A byte is accepted on a rising edge where `tx_valid && tx_ready`. No back-pressure timeout.
- `tx_valid` while `!tx_ready` drops the byte and sets `overflow`.
- `overflow` clears on `clr_ovf`. If set and clear occur in the same cycle, set wins.

FIFO:
- Registered circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits. The MSB distinguishes full from empty; pointers wrap naturally.
- Push and pop may occur in the same cycle; `fifo_count` is then unchanged.
- When full, `tx_ready` is 0 even if a pop happens in the same cycle. No pass-through.

Transmit FSM states:
- IDLE: SOUT=1. If the FIFO is non-empty, pop one byte into `shreg` and go to START.
- START: SOUT=0 for CLKS_PER_BIT cycles, then go to DATA with `bit_idx`=0.
- DATA: SOUT=`shreg[0]`. Every CLKS_PER_BIT cycles, shift `shreg` right and increment `bit_idx`. After bit 7, go to STOP.
- STOP: SOUT=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.

Counters:
- Baud counter runs 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary.
- `bit_idx` is 3 bits.

SOUT register:
- SOUT is driven from a register, so it is glitch-free.

## Timing

Reset (`RST_PER_N`=0 sampled on an edge) gives:
- SOUT=1, `tx_busy`=0, `tx_ready`=1, `fifo_count`=0, `overflow`=0.
- FIFO pointers and counters are zeroed; FSM goes to IDLE.

Reset mid-frame:
- The frame is aborted and SOUT is high after that edge.
- The queue is flushed, and the partial byte is lost.

Latency:
- A byte accepted at edge N into an empty, idle block gives SOUT=0 from edge N+2. (Pop occurs at edge N+1, START is registered at edge N+2.)
- `tx_busy` rises at edge N+2.

Frame timing:
- Frame length is exactly 10×CLKS_PER_BIT cycles, i.e. 2170 cycles (43.4 µs) at the default.
- Back-to-back frames from the queue are contiguous: the next start bit follows the stop bit with zero idle cycles.

`tx_ready`:
- Combinational from registered pointers, so it updates the cycle after a push or pop.

## Structure

Shared package `uart_pkg`:
- UART state enum: IDLE/START/DATA/STOP.
- `UART_CLKS_PER_BIT`=217 and `UART_DATA_BITS`=8.
- The SIN receiver uses the same package so that the bit period is defined once.

Sub-module:
- `byte_fifo`, a parameterised synchronous FIFO with push, pop, dout, full, empty and count. It is reusable for the receive side.
- The top level holds only the FSM, the baud counter and the overflow logic.

## Test plan

1. Reset, then push 8'hAB.
   - SOUT sequence per bit period: 0,1,1,0,1,0,1,0,1,1.
   - Start edge occurs 2 cycles after acceptance.
   - `tx_busy` is high for 2170 cycles.
2. Push 8'hAB then 8'hCD on consecutive cycles.
   - Two frames with no idle gap between them.
   - Second frame data bits are 1,0,1,1,0,0,1,1.
   - `fifo_count` goes 1, then 0 when the second byte pops.
3. Push 17 bytes 8'h00..8'h10 with SOUT busy.
   - `tx_ready` drops once 16 bytes are queued.
   - The 17th byte sets `overflow`; 8'h10 is never transmitted.
   - `clr_ovf` clears `overflow`.
4. Hold `tx_valid` on a full FIFO through a pop cycle.
   - Exactly one byte is accepted, on the cycle after the pop.
   - `fifo_count` returns to 16.
5. Assert `RST_PER_N`=0 in the middle of data bit 4 of a frame, with 3 bytes queued.
   - SOUT=1 from the next edge; `fifo_count`=0; `tx_busy`=0.
   - No further start bits.
6. Loopback of SOUT into the existing SIN receiver for 8'h00, 8'hFF, 8'h55 and 8'hAA.
   - Received bytes match the transmitted bytes, with no framing errors.
